// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a bank of common-anode 7-segment digits.
// A packed hex word and a per-digit decimal-point mask are captured into
// shadow registers on `load`. The driver then selects one digit at a time and
// holds it for REFRESH_DIV clock cycles. The anode select and the segment
// pattern are active-low and change only on a scan tick.
//
// Parameters
//   NUM_DIGITS   number of scanned digits, 1..8
//   REFRESH_DIV  clk cycles each digit stays selected, >= 2
//
// Ports
//   clk        in   system clock, all state on rising edge
//   reset      in   synchronous active-high reset
//   value      in   packed hex digits, digit k = value[4k+3:4k]
//   dp_mask    in   bit k lights the decimal point of digit k
//   load       in   capture value/dp_mask into the shadow registers
//   anode      out  active-low one-hot digit select (registered)
//   catode     out  active-low segments {A,B,C,D,E,F,G,P} (registered)
//   digit_idx  out  index of the currently driven digit (registered)
//
// Optional feature
//   SEG7_LEADING_ZERO_BLANK_EN : when defined, blanks the segments of leading
//   zero digits (digit 0 is never blanked, decimal points still follow
//   dp_mask). When undefined, no blanking logic exists.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              catode,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Hex nibble to active-high segments, bit order A..G = [6:0].
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      4'hF:    seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  // State flops
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]              catode_q, catode_d;

  // Combinational helpers
  logic                    tick_s;
  logic [IDX_W-1:0]        idx_nxt_s;
  logic [3:0]              nib_arr_s [NUM_DIGITS];
  logic [3:0]              nib_sel_s;
  logic                    dp_sel_s;
  logic                    blank_sel_s;
  logic [NUM_DIGITS-1:0]   blank_s;
  logic [6:0]              seg_sel_s;

  assign tick_s = (pre_q == LAST_PRE);

  // Split the shadow word into one nibble per digit for indexed selection.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nib_arr_s[k] = val_q[4*k +: 4];
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic zero_run_s;

  // Flag digits whose nibble and every more-significant nibble are zero.
  always_comb begin
    blank_s    = {NUM_DIGITS{1'b0}};
    zero_run_s = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run_s = zero_run_s & (val_q[4*k +: 4] == 4'h0);
      blank_s[k] = zero_run_s;
    end
  end
`else
  assign blank_s = {NUM_DIGITS{1'b0}};
`endif

  // Select the digit that becomes active on the next tick and build its pattern.
  always_comb begin
    if (idx_q == LAST_IDX) begin
      idx_nxt_s = {IDX_W{1'b0}};
    end else begin
      idx_nxt_s = idx_q + IDX_W'(1'b1);
    end
    nib_sel_s   = nib_arr_s[idx_nxt_s];
    dp_sel_s    = dp_q[idx_nxt_s];
    blank_sel_s = blank_s[idx_nxt_s];
    if (blank_sel_s) begin
      seg_sel_s = 7'b0000000;
    end else begin
      seg_sel_s = seg7_decode(nib_sel_s);
    end
  end

  // Next-state logic: shadow capture, prescaler and tick-driven output update.
  always_comb begin
    val_d    = val_q;
    dp_d     = dp_q;
    pre_d    = pre_q;
    idx_d    = idx_q;
    anode_d  = anode_q;
    catode_d = catode_q;

    if (load) begin
      val_d = value;
      dp_d  = dp_mask;
    end else begin
      val_d = val_q;
      dp_d  = dp_q;
    end

    // The tick encodes the old shadow contents even when load hits the same
    // edge, because the pattern is built from val_q/dp_q, not val_d/dp_d.
    if (tick_s) begin
      pre_d    = {PRE_W{1'b0}};
      idx_d    = idx_nxt_s;
      anode_d  = ~(NUM_DIGITS'(1'b1) << idx_nxt_s);
      catode_d = ~{seg_sel_s, dp_sel_s};
    end else begin
      pre_d    = pre_q + PRE_W'(1'b1);
      idx_d    = idx_q;
      anode_d  = anode_q;
      catode_d = catode_q;
    end
  end

  // State registers with synchronous reset that dominates load and tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q    <= {(4*NUM_DIGITS){1'b0}};
      dp_q     <= {NUM_DIGITS{1'b0}};
      pre_q    <= {PRE_W{1'b0}};
      idx_q    <= LAST_IDX;
      anode_q  <= {NUM_DIGITS{1'b1}};
      catode_q <= 8'hFF;
    end else begin
      val_q    <= val_d;
      dp_q     <= dp_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      anode_q  <= anode_d;
      catode_q <= catode_d;
    end
  end

  assign anode     = anode_q;
  assign catode    = catode_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// Testbench for seg7_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4).
// Stimulus updates a behavioural model on every clock edge and queues the
// expected output triple; a monitor pops and compares on each falling edge.
// A few directed points from the datasheet examples are compared to literals.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  anode;
  logic [7:0]  catode;
  logic [1:0]  digit_idx;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .dp_mask   (dp_mask),
    .load      (load),
    .anode     (anode),
    .catode    (catode),
    .digit_idx (digit_idx)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] cat;
    logic [1:0] idx;
  } exp_t;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  // Behavioural model: shadow digits, edges since reset, current outputs.
  logic [3:0] m_nib [N];
  logic [3:0] m_dp;
  int         m_edges;
  exp_t       m_out;

  function automatic logic [7:0] exp_cat(input int d);
    logic [6:0] s;
    bit all0;
    s = SEG_TAB[m_nib[d]];
    all0 = 1'b1;
    for (int j = d; j < N; j++) if (m_nib[j] != 4'h0) all0 = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d >= 1 && all0) s = 7'b0000000;
`endif
    return ~{s, m_dp[d]};
  endfunction

  task automatic model_edge(input logic r, input logic l, input logic [15:0] v,
                            input logic [3:0] dm);
    int d;
    if (r) begin
      for (int j = 0; j < N; j++) m_nib[j] = 4'h0;
      m_dp      = 4'h0;
      m_edges   = 0;
      m_out.an  = 4'b1111;
      m_out.cat = 8'hFF;
      m_out.idx = 2'(N - 1);
    end else begin
      m_edges++;
      if (m_edges % RD == 0) begin
        d = ((m_edges / RD) - 1) % N;
        m_out.an  = 4'b1111 & ~(4'b0001 << d);
        m_out.cat = exp_cat(d);
        m_out.idx = 2'(d);
      end
      if (l) begin
        for (int j = 0; j < N; j++) m_nib[j] = v[4*j +: 4];
        m_dp = dm;
      end
    end
    sb_q.push_back(m_out);
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] v,
                      input logic [3:0] dm);
    @(negedge clk);
    reset = r; load = l; value = v; dp_mask = dm;
    @(posedge clk);
    model_edge(r, l, v, dm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 4'h0);
  endtask

  task automatic chk(input string name, input logic [3:0] an, input logic [7:0] cat);
    #2;
    checks++;
    if (anode !== an || catode !== cat) begin
      failures++;
      $display("FAIL %s: anode=%b catode=%h, required anode=%b catode=%h",
               name, anode, catode, an, cat);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (anode !== e.an || catode !== e.cat || digit_idx !== e.idx) begin
          failures++;
          $display("FAIL scoreboard t=%0t: anode=%b catode=%h idx=%0d, required anode=%b catode=%h idx=%0d",
                   $time, anode, catode, digit_idx, e.an, e.cat, e.idx);
        end
      end
    end
  end

  initial begin
    logic [15:0] rv;
    // Reset and the first tick without any load
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    chk("reset_dark", 4'b1111, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("pre_first_tick_dark", 4'b1111, 8'hFF);
    end
    idle(1);
    chk("first_tick_zero", 4'b1110, 8'h03);

    // 12AF scan, load on a tick edge, wrap and mid-frame reset
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b1, 16'h12AF, 4'h0);
    idle(3);  chk("d0_F", 4'b1110, 8'h71);
    idle(3);  chk("d0_hold", 4'b1110, 8'h71);
    idle(1);  chk("d1_A", 4'b1101, 8'h11);
    idle(3);
    step(1'b0, 1'b1, 16'h1111, 4'h0);
    chk("d2_old_on_load_tick", 4'b1011, 8'h25);
    idle(4);  chk("d3_new_1", 4'b0111, 8'h9F);
    idle(4);  chk("wrap_d0_new", 4'b1110, 8'h9F);
    idle(9);  chk("d2_active", 4'b1011, 8'h9F);
    step(1'b1, 1'b1, 16'hFFFF, 4'hF);
    chk("midframe_reset", 4'b1111, 8'hFF);
    idle(4);  chk("after_reset_d0", 4'b1110, 8'h03);

    // All zeros with one decimal point
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b1, 16'h0000, 4'b0010);
    idle(3);  chk("zero_d0", 4'b1110, 8'h03);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    idle(4);  chk("zero_d1_dp", 4'b1101, 8'hFE);
    idle(4);  chk("zero_d2", 4'b1011, 8'hFF);
    idle(4);  chk("zero_d3", 4'b0111, 8'hFF);
`else
    idle(4);  chk("zero_d1_dp", 4'b1101, 8'h02);
    idle(4);  chk("zero_d2", 4'b1011, 8'h03);
    idle(4);  chk("zero_d3", 4'b0111, 8'h03);
`endif

    // 0003: leading zeros
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b1, 16'h0003, 4'h0);
    idle(3);  chk("v3_d0", 4'b1110, 8'h0D);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    idle(4);  chk("v3_d1", 4'b1101, 8'hFF);
    idle(8);  chk("v3_d3", 4'b0111, 8'hFF);
`else
    idle(4);  chk("v3_d1", 4'b1101, 8'h03);
    idle(8);  chk("v3_d3", 4'b0111, 8'h03);
`endif

    // Randomized traffic with occasional resets and sparse high nibbles
    for (int i = 0; i < 3000; i++) begin
      rv = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rv = rv & 16'h000F;
        1:       rv = rv & 16'h00FF;
        default: rv = rv;
      endcase
      step(($urandom_range(0, 249) == 0), ($urandom_range(0, 9) == 0), rv,
           4'($urandom));
    end
    idle(4);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
